wishbone_decoder: RTL and testbench
===================================

# wishbone_decoder

Slave-side Wishbone classic interconnect stage sitting behind `wishbone_arbiter`: it takes the single granted master cycle and routes it to one of four slaves by address. It latches the decoded slave per transfer and returns that slave's ACK, ERR and read data to the master. A watchdog generates a bus error for unmapped addresses and for slaves that never terminate a transfer.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `SLV_BASE`, {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}: concatenated 4×ADDR_W base addresses, slave 0 in LSBs.
- `SLV_MASK`, {4{32'hF000_0000}}: concatenated 4×ADDR_W compare masks.
- `TIMEOUT`, 255: watchdog limit in ACTIVE cycles; 0 disables the watchdog.

Ports:
- `CLK` in 1: clock, all state updates on the rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `CYC_I`, `STB_I`, `WE_I` in 1: master cycle, strobe and write enable.
- `ADR_I` in ADDR_W; `DAT_I` in DATA_W; `SEL_I` in DATA_W/8: master address, write data and byte selects.
- `ACK_O`, `ERR_O` out 1: transfer termination to the master.
- `DAT_O` out DATA_W: read data to the master.
- `CYC_O`, `STB_O` out 4: per-slave cycle and strobe.
- `ADR_O`, `DAT_WO`, `SEL_O`, `WE_O` out: unregistered broadcast of `ADR_I`, `DAT_I`, `SEL_I` and `WE_I`.
- `ACK_I`, `ERR_I` in 4: per-slave terminations.
- `DAT_RI` in 4×DATA_W: concatenated slave read data, slave 0 in LSBs.

## Operation
- Hit rule: slave i is hit when `(ADR_I & MASK_i) == BASE_i`. On overlapping maps the lowest index wins.
- State machine has three states: IDLE, ACTIVE and ERROR.
- **IDLE**
  - With `CYC_I & STB_I` and a hit: register `sel_q` = hit index, clear the watchdog, go to ACTIVE.
  - With `CYC_I & STB_I` and no hit: go to ERROR.
  - Otherwise stay in IDLE.
- **ACTIVE**
  - `CYC_O[sel_q] = CYC_I`, `STB_O[sel_q] = STB_I`, all other bits 0.
  - `ACK_O = ACK_I[sel_q] & ~ERR_I[sel_q]`, `ERR_O = ERR_I[sel_q]`, `DAT_O = DAT_RI[sel_q]`.
  - Any sampled termination (`ACK_I[sel_q]` or `ERR_I[sel_q]`) returns to IDLE.
  - `CYC_I` low returns to IDLE (abort); slave outputs drop combinationally.
  - Watchdog at `TIMEOUT-1` with no termination goes to ERROR.
- **ERROR**
  - `ERR_O = CYC_I & STB_I` for exactly one cycle, all `CYC_O`/`STB_O` are 0, then unconditionally IDLE.
- Every transfer is decoded anew, including successive strobes inside one `CYC_I` block.
- Outside ACTIVE, `ACK_O = 0` and `DAT_O = 0`.
- Terminations from non-selected slaves are ignored.
- Reset values: state IDLE, `sel_q` = 0, watchdog = 0, `ACK_O`/`ERR_O`/`CYC_O`/`STB_O` = 0, `DAT_O` = 0.

## Timing
- Decode latency is one cycle: a request sampled at edge k drives `STB_O[sel]` during cycle k+1.
- Termination is combinational from the slave: a slave ACK in cycle k+1 gives `ACK_O` in cycle k+1, and the state is IDLE after edge k+2.
- Minimum transfer is 2 cycles; back-to-back transfers take 2 cycles each.
- Watchdog is 0 in the first ACTIVE cycle and increments each ACTIVE cycle without termination. With `TIMEOUT`=255 and no ACK, ERROR is entered after 255 ACTIVE cycles, so `ERR_O` rises in the 256th cycle after ACTIVE entry.
- A termination on the same edge the watchdog expires takes priority: the slave's ACK or ERR is forwarded and no timeout ERR is generated.
- `ACK_I` and `ERR_I` high together on the selected slave: ERR wins and `ACK_O` stays 0.
- Unmapped request: `ERR_O` is high in cycle k+1 and IDLE is re-entered at edge k+2.
- `RST_N` falling mid-transfer: all outputs go to their reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `wb_pkg` holds:
  - the state encoding (IDLE=0, ACTIVE=1, ERROR=2);
  - `WB_NSLV`=4;
  - default base and mask constants.
- Sub-module `wb_watchdog`: parameterized down-counter with `clear`, `en` and `expired` outputs, sized `$clog2(TIMEOUT+1)`.
- The decoder, slave mux and FSM stay in `wishbone_decoder`.

## Test plan
- **Reset:** hold `RST_N`=0 with `CYC_I`/`STB_I`=1 → all outputs 0; release → first decode occurs one cycle later.
- **Read to slave 2:** `ADR_I`=32'h2000_0010, slave 2 ACKs immediately with `DAT_RI`=32'hDEAD_BEEF → `STB_O`=4'b0100 in cycle 1; `ACK_O`=1 and `DAT_O`=32'hDEAD_BEEF in cycle 1; IDLE in cycle 2.
- **Unmapped:** `ADR_I`=32'h4000_0000 → `STB_O`=0 throughout, `ERR_O`=1 for exactly 1 cycle.
- **Timeout:** `TIMEOUT`=4, slave 1 never ACKs → `STB_O[1]` high for 4 cycles, then `ERR_O` for 1 cycle, then IDLE. A repeat where the ACK arrives in the 4th ACTIVE cycle → `ACK_O` and no `ERR_O`.
- **Abort and conflicts:**
  - drop `CYC_I` during ACTIVE → IDLE next edge, `CYC_O` low immediately;
  - selected slave asserts ACK and ERR together → only `ERR_O`;
  - non-selected slave ACKs → `ACK_O` stays 0.
- **Async reset mid-transfer:** pulse `RST_N` low between edges during ACTIVE → outputs clear before the next edge, state IDLE.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared constants and types for the Wishbone slave decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int WB_NSLV    = 4;
    localparam int c_wb_idx_w = $clog2(WB_NSLV);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } wb_state_e;

    localparam logic [WB_NSLV*32-1:0] c_wb_def_base =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [WB_NSLV*32-1:0] c_wb_def_mask = {WB_NSLV{32'hF000_0000}};

    // Overlapping address maps resolve to the lowest slave index.
    function automatic logic [c_wb_idx_w-1:0] wb_first_hit(input logic [WB_NSLV-1:0] hit);
        logic [c_wb_idx_w-1:0] idx;
        idx = '0;
        for (int i = WB_NSLV - 1; i >= 0; i--) begin
            if (hit[i]) idx = c_wb_idx_w'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : wb_watchdog
//  Description : Transfer watchdog; down-counter loaded on clear, expired at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT > 0) begin : g_enabled
            localparam int               c_cnt_w = $clog2(TIMEOUT + 1);
            localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(TIMEOUT - 1);

            logic [c_cnt_w-1:0] r_count;

            // Loaded with TIMEOUT-1 so it reaches 0 in the TIMEOUT-th enabled cycle.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= c_load;
                end else if (en && (r_count != '0)) begin
                    r_count <= r_count - 1'b1;
                end
            end

            assign expired = (r_count == '0);
        end else begin : g_disabled
            logic w_unused;
            assign w_unused = CLK ^ RST_N ^ clear ^ en;
            assign expired  = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wishbone_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : wishbone_decoder
//  Description : Wishbone classic address decoder / slave mux with watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module wishbone_decoder
    import wb_pkg::*;
#(
    parameter int                        ADDR_W   = 32,
    parameter int                        DATA_W   = 32,
    parameter logic [WB_NSLV*ADDR_W-1:0] SLV_BASE = c_wb_def_base,
    parameter logic [WB_NSLV*ADDR_W-1:0] SLV_MASK = c_wb_def_mask,
    parameter int                        TIMEOUT  = 255
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      CYC_I,
    input  logic                      STB_I,
    input  logic                      WE_I,
    input  logic [ADDR_W-1:0]         ADR_I,
    input  logic [DATA_W-1:0]         DAT_I,
    input  logic [DATA_W/8-1:0]       SEL_I,
    output logic                      ACK_O,
    output logic                      ERR_O,
    output logic [DATA_W-1:0]         DAT_O,
    output logic [WB_NSLV-1:0]        CYC_O,
    output logic [WB_NSLV-1:0]        STB_O,
    output logic [ADDR_W-1:0]         ADR_O,
    output logic [DATA_W-1:0]         DAT_WO,
    output logic [DATA_W/8-1:0]       SEL_O,
    output logic                      WE_O,
    input  logic [WB_NSLV-1:0]        ACK_I,
    input  logic [WB_NSLV-1:0]        ERR_I,
    input  logic [WB_NSLV*DATA_W-1:0] DAT_RI
);

    wb_state_e               r_state;
    wb_state_e               w_state_nxt;
    logic [c_wb_idx_w-1:0]   r_sel;
    logic [WB_NSLV-1:0]      w_hit;
    logic [c_wb_idx_w-1:0]   w_hit_idx;
    logic                    w_load;
    logic                    w_wd_clear;
    logic                    w_wd_en;
    logic                    w_wd_expired;
    logic                    w_sel_ack;
    logic                    w_sel_err;
    logic [DATA_W-1:0]       w_sel_dat;

    assign ADR_O  = ADR_I;
    assign DAT_WO = DAT_I;
    assign SEL_O  = SEL_I;
    assign WE_O   = WE_I;

    generate
        for (genvar gi = 0; gi < WB_NSLV; gi++) begin : g_hit
            assign w_hit[gi] = ((ADR_I & SLV_MASK[gi*ADDR_W +: ADDR_W])
                                == SLV_BASE[gi*ADDR_W +: ADDR_W]);
        end
    endgenerate

    assign w_hit_idx = wb_first_hit(w_hit);

    assign w_sel_ack = ACK_I[r_sel];
    assign w_sel_err = ERR_I[r_sel];
    assign w_sel_dat = DAT_RI[r_sel*DATA_W +: DATA_W];

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clear   (w_wd_clear),
        .en      (w_wd_en),
        .expired (w_wd_expired)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) r_sel <= w_hit_idx;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_wd_clear  = 1'b0;
        w_wd_en     = 1'b0;
        CYC_O       = '0;
        STB_O       = '0;
        ACK_O       = 1'b0;
        ERR_O       = 1'b0;
        DAT_O       = '0;
        case (r_state)
            ST_IDLE: begin
                if (CYC_I && STB_I) begin
                    if (|w_hit) begin
                        w_load      = 1'b1;
                        w_wd_clear  = 1'b1;
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_state_nxt = ST_ERROR;
                    end
                end
            end
            ST_ACTIVE: begin
                CYC_O[r_sel] = CYC_I;
                STB_O[r_sel] = STB_I;
                ACK_O        = w_sel_ack & ~w_sel_err;
                ERR_O        = w_sel_err;
                DAT_O        = w_sel_dat;
                // A slave termination beats both an abort and a watchdog expiry.
                if (w_sel_ack || w_sel_err) begin
                    w_state_nxt = ST_IDLE;
                end else if (!CYC_I) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wd_en = 1'b1;
                    if (w_wd_expired) w_state_nxt = ST_ERROR;
                end
            end
            ST_ERROR: begin
                ERR_O       = CYC_I & STB_I;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wishbone_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wishbone_decoder
//  Description : Randomized transaction-level bench for wishbone_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_decoder;

    localparam int TO = 4;

    logic         CLK   = 1'b0;
    logic         RST_N = 1'b0;
    logic         CYC_I = 1'b0;
    logic         STB_I = 1'b0;
    logic         WE_I  = 1'b0;
    logic [31:0]  ADR_I = '0;
    logic [31:0]  DAT_I = '0;
    logic [3:0]   SEL_I = '0;
    logic         ACK_O;
    logic         ERR_O;
    logic [31:0]  DAT_O;
    logic [3:0]   CYC_O;
    logic [3:0]   STB_O;
    logic [31:0]  ADR_O;
    logic [31:0]  DAT_WO;
    logic [3:0]   SEL_O;
    logic         WE_O;
    logic [3:0]   ACK_I  = '0;
    logic [3:0]   ERR_I  = '0;
    logic [127:0] DAT_RI = '0;

    int n_checks = 0;
    int n_pass   = 0;
    bit fix_dat  = 1'b0;

    logic [31:0] m_base [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    logic [31:0] m_mask [4] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    wishbone_decoder #(
        .TIMEOUT (TO)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .CYC_I  (CYC_I),
        .STB_I  (STB_I),
        .WE_I   (WE_I),
        .ADR_I  (ADR_I),
        .DAT_I  (DAT_I),
        .SEL_I  (SEL_I),
        .ACK_O  (ACK_O),
        .ERR_O  (ERR_O),
        .DAT_O  (DAT_O),
        .CYC_O  (CYC_O),
        .STB_O  (STB_O),
        .ADR_O  (ADR_O),
        .DAT_WO (DAT_WO),
        .SEL_O  (SEL_O),
        .WE_O   (WE_O),
        .ACK_I  (ACK_I),
        .ERR_I  (ERR_I),
        .DAT_RI (DAT_RI)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int ref_slave(input logic [31:0] addr);
        for (int i = 0; i < 4; i++) begin
            if ((addr & m_mask[i]) == m_base[i]) return i;
        end
        return -1;
    endfunction

    // One bus cycle: drive inputs after the falling edge, then compare outputs.
    task automatic step(input logic cyc, input logic stb, input logic [3:0] ack,
                        input logic [3:0] err, input logic [3:0] e_stb,
                        input logic e_ack, input logic e_err, input int e_dsel);
        logic [31:0] e_dat;
        @(negedge CLK);
        CYC_I = cyc;
        STB_I = stb;
        ACK_I = ack;
        ERR_I = err;
        for (int i = 0; i < 4; i++) DAT_RI[i*32 +: 32] = $urandom;
        if (fix_dat) DAT_RI[95:64] = 32'hDEAD_BEEF;
        #1;
        e_dat = '0;
        if (e_dsel >= 0) e_dat = DAT_RI[e_dsel*32 +: 32];
        check_eq("stb_o", STB_O, e_stb);
        check_eq("cyc_o", CYC_O, e_stb & {4{cyc}});
        check_eq("ack_o", ACK_O, e_ack);
        check_eq("err_o", ERR_O, e_err);
        check_eq("dat_o", DAT_O, e_dat);
        check_eq("bcast", {WE_O, SEL_O, DAT_WO, ADR_O}, {WE_I, SEL_I, DAT_I, ADR_I});
    endtask

    // kind: 0 ACK, 1 ERR, 2 ACK+ERR. d: ACTIVE cycle of slave reply (0 = never).
    task automatic run_txn(input logic [31:0] addr, input int d, input int kind,
                           input int abort_at, input int gap);
        int          s;
        logic [3:0]  sbit;
        logic [3:0]  na;
        logic [3:0]  ne;
        logic        a_s;
        logic        e_s;
        int          g;
        s     = ref_slave(addr);
        ADR_I = addr;
        WE_I  = 1'($urandom);
        DAT_I = $urandom;
        SEL_I = 4'($urandom);
        g     = gap;
        step(1'b1, 1'b1, 4'($urandom), 4'($urandom), 4'b0, 1'b0, 1'b0, -1);
        if (s < 0) begin
            step(1'b1, 1'b1, 4'($urandom), 4'($urandom), 4'b0, 1'b0, 1'b1, -1);
        end else begin
            sbit = 4'(1 << s);
            for (int n = 1; n <= TO + 1; n++) begin
                na = 4'($urandom) & ~sbit;
                ne = 4'($urandom) & ~sbit;
                if (n == TO + 1) begin
                    step(1'b1, 1'b1, 4'($urandom), 4'($urandom), 4'b0, 1'b0, 1'b1, -1);
                    break;
                end else if (n == abort_at) begin
                    step(1'b0, 1'b0, na, ne, 4'b0, 1'b0, 1'b0, s);
                    if (g == 0) g = 1;
                    break;
                end else if (n == d) begin
                    a_s = (kind != 1);
                    e_s = (kind != 0);
                    step(1'b1, 1'b1, na | (a_s ? sbit : 4'b0), ne | (e_s ? sbit : 4'b0),
                         sbit, a_s & ~e_s, e_s, s);
                    break;
                end else begin
                    step(1'b1, 1'b1, na, ne, sbit, 1'b0, 1'b0, s);
                end
            end
        end
        for (int i = 0; i < g; i++)
            step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'b0, 1'b0, 1'b0, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        // Reset held with a live request: nothing may propagate.
        ADR_I = 32'h2000_0010;
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 4'($urandom), 4'($urandom), 4'b0, 1'b0, 1'b0, -1);
        @(posedge CLK);
        #2 RST_N = 1'b1;

        fix_dat = 1'b1;
        run_txn(32'h2000_0010, 1, 0, 0, 1);
        fix_dat = 1'b0;

        run_txn(32'h4000_0000, 0, 0, 0, 1);
        run_txn(32'h1000_0040, 0, 0, 0, 1);
        run_txn(32'h1000_0040, 4, 0, 0, 1);
        run_txn(32'h3000_0008, 0, 0, 2, 1);
        run_txn(32'h0000_1234, 2, 2, 0, 0);
        run_txn(32'h2000_0004, 3, 1, 0, 0);
        run_txn(32'h7FFF_FFFC, 1, 0, 0, 0);

        // Asynchronous reset pulse while a transfer is active.
        ADR_I = 32'h0000_0100;
        step(1'b1, 1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, -1);
        step(1'b1, 1'b1, 4'b0, 4'b0, 4'b0001, 1'b0, 1'b0, 0);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check_eq("rst_async", {CYC_O, STB_O, ACK_O, ERR_O, DAT_O}, '0);
        #1 RST_N = 1'b1;
        step(1'b1, 1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, -1);
        step(1'b1, 1'b1, 4'b0001, 4'b0, 4'b0001, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, -1);

        for (int t = 0; t < 200; t++) begin
            logic [31:0] addr;
            int          d;
            int          kind;
            int          ab;
            int          gap;
            addr = {1'b0, 3'($urandom), 28'($urandom)};
            d    = $urandom_range(0, 6);
            kind = $urandom_range(0, 2);
            ab   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            gap  = $urandom_range(0, 2);
            run_txn(addr, d, kind, ab, gap);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
